// File: rtl/dram_port_arbiter.sv
// Two-master arbiter for the single-port data RAM. Round-robin per-cycle
// grant, an optional lock so one master can own the port across a
// compare-and-swap sequence, a watchdog that breaks over-long locks, and a
// registered read-data return one cycle after each granted read.
module dram_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_spo,
  output logic [1:0]    lock_owner,
  output logic          lock_timeout
);

  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  // State encoding doubles as the one-hot lock_owner output.
  typedef enum logic [1:0] {
    FREE    = 2'b00,
    LOCKED0 = 2'b01,
    LOCKED1 = 2'b10
  } lock_state_e;

  lock_state_e   state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rr_last_q, rr_last_d;
  logic          timeout_q;
  logic          wd_fire;

  // Watchdog fires on the last permitted locked cycle.
  assign wd_fire = (state_q != FREE) && (lock_cnt_q == CNT_LAST);

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FREE;
    else     state_q <= state_d;
  end

  // Lock next-state: acquire on a locked grant, release on lock drop or watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE: begin
        if (m0_gnt && m0_lock)      state_d = LOCKED0;
        else if (m1_gnt && m1_lock) state_d = LOCKED1;
      end
      LOCKED0: if (wd_fire || !m0_lock) state_d = FREE;
      LOCKED1: if (wd_fire || !m1_lock) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // Grant, memory mux and lock_owner; the lock filters, then round-robin breaks ties.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      unique case (state_q)
        LOCKED0: m0_gnt = m0_req;
        LOCKED1: m1_gnt = m1_req;
        default: begin
          if (m0_req && m1_req) begin
            m0_gnt = rr_last_q;
            m1_gnt = !rr_last_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
      endcase
    end
    mem_a      = m1_gnt ? m1_addr  : m0_addr;
    mem_d      = m1_gnt ? m1_wdata : m0_wdata;
    mem_we     = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    lock_owner = state_q;
  end

  // Round-robin pointer and lock counter next values.
  always_comb begin
    rr_last_d = rr_last_q;
    if (wd_fire)     rr_last_d = (state_q == LOCKED1);
    else if (m0_gnt) rr_last_d = 1'b0;
    else if (m1_gnt) rr_last_d = 1'b1;
    // Count only while staying locked; entering a lock starts at zero.
    lock_cnt_d = '0;
    if (state_q != FREE && state_d != FREE) lock_cnt_d = lock_cnt_q + 1'b1;
  end

  // Arbitration bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q  <= 1'b1;
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
      timeout_q  <= wd_fire;
    end
  end

  assign lock_timeout = timeout_q;

  // Master 0 read return: capture RAM data on a granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_spo;
    end
  end

  // Master 1 read return: capture RAM data on a granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m1_rvalid <= m1_gnt && !m1_we;
      if (m1_gnt && !m1_we) m1_rdata <= mem_spo;
    end
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port 1024x32 distributed data RAM (write-enable, address, write data in; combinational read data out) between two requesters:
  - master 0: the sort engine.
  - master 1: the host/browse path (prior/next/start stepping, result display).
- Per-cycle arbitration is round-robin.
- Supports a lock so a master can own the port across a multi-access compare-and-swap sequence.
- A lock watchdog prevents starvation.
- Read data is registered and returned one cycle after the granted access.

Parameters:
- AW, 10, RAM address width.
- DW, 32, RAM data width.
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  master 0 requests an access this cycle.
- m0_we  in  1  master 0 access is a write.
- m0_lock  in  1  master 0 wants to keep the port after this access.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 access performed this cycle (combinational).
- m0_rvalid  out  1  read data for master 0 valid (registered).
- m0_rdata  out  DW  registered read data for master 0.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0.
- mem_we  out  1  RAM write enable.
- mem_a  out  AW  RAM address.
- mem_d  out  DW  RAM write data.
- mem_spo  in  DW  RAM combinational read data.
- lock_owner  out  2  bit i set while master i holds the lock (one-hot or zero).
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - lock_owner=0, lock_cnt=0, rr_last=1 (so master 0 wins the first tie).
  - m0_rvalid=m1_rvalid=0; m0_rdata=m1_rdata=0; lock_timeout=0.
  - While rst is high, gnt outputs and mem_we are forced 0 combinationally.
  - Reset mid-lock or mid-read drops everything; no rvalid follows.
- Grant is combinational, evaluated every cycle in priority order:
  - Lock held by master i: only master i may be granted, and only when mi_req=1. The other master waits even if the owner is idle.
  - Otherwise, exactly one requester: grant it.
  - Otherwise, both requesting: grant the master != rr_last.
  - At most one gnt is high per cycle.
- Memory drive:
  - mem_a and mem_d are muxed from the granted master. With no grant they come from master 0.
  - mem_we = gnt & we of the granted master.
- Read return:
  - On a granted read (we=0), mX_rdata <= mem_spo at the clock edge; mX_rvalid=1 for the next cycle only.
  - A granted write produces no rvalid.
  - Back-to-back reads return back-to-back rvalid.
  - rdata holds its value when rvalid=0.
- rr_last <= index of the granted master on every granted cycle; it is unchanged otherwise.
- Lock state machine (per arbiter: FREE, LOCKED0, LOCKED1):
  - FREE -> LOCKEDi: when master i is granted with mi_lock=1.
  - LOCKEDi -> FREE, either of:
    - the owner is granted with mi_lock=0 (final access of the sequence, still performed);
    - the owner has mi_req=0 and mi_lock=0.
  - lock_cnt resets to 0 on entering LOCKEDi and increments each cycle in LOCKEDi.
  - Watchdog: when lock_cnt==LOCK_MAX-1, the next edge forces FREE and pulses lock_timeout for one cycle. rr_last is set to i so the other master wins the next tie. An access granted in that final cycle still completes normally.
  - While the lock is forced free, the owner's lock bit is ignored for the cycle it is released. It may re-lock on a later grant.
- Simultaneous events:
  - A lock request and a tie in FREE: round-robin decides; only the winner's lock takes effect.
  - Owner release and a waiting master: the waiter may be granted on the cycle after release, never the same cycle.
- Addresses wrap naturally at AW bits; no range checking.

Test Plan:
- Reset, then m0 reads addr 5 (RAM[5]=0x1234) -> m0_gnt=1 same cycle, mem_a=5; next cycle m0_rvalid=1, m0_rdata=0x1234; m1 signals idle.
- Both masters request reads every cycle for 4 cycles -> grants alternate m0,m1,m0,m1; each rvalid follows its grant by exactly one cycle.
- m0 locks and runs read 3, read 4, write 3=0xAA, write 4=0xBB (lock=0 on the last access) while m1 requests continuously:
  - m1_gnt=0 for all 4 cycles, lock_owner=01;
  - m1 is granted in cycle 5;
  - RAM[3]=0xAA, RAM[4]=0xBB.
- m1 locks with m1_req held low while m0 requests -> m0 is never granted; after LOCK_MAX=16 cycles lock_timeout pulses once, lock_owner=00, and m0 is granted the following cycle.
- m1 writes addr 1023 (0xFFFFFFFF) while m0 is idle -> mem_we=1 only in the grant cycle; no rvalid on either master.
- Assert rst while m0 holds the lock with a read granted in the same cycle -> no rvalid next cycle, lock_owner=00, mem_we=0 during rst, and m0 wins the first tie after reset.
